reimu_shot: RTL
===============

// Module: reimu_shot
// PURPOSE
//  Player shot manager, directly downstream of the player-movement stage.
//  Consumes the player position (reimux/reimuy) and a fire key.
//  Spawns shots into a fixed pool of slots, moves them upward one step per clk22 tick,
//  and retires them when they leave the top of the playfield.
//  Slot positions feed the renderer and the enemy-hit logic.
// PARAMETERS
//  NSHOT     4   number of shot slots (1..8)
//  SPEED     4   pixels a shot moves up per tick (1..15)
//  COOLDOWN  8   minimum ticks between consecutive spawns (>=1)
//  X_OFFSET  16  added to reimux to centre the shot on the sprite
// PORTS
//  clk22       in   1           game tick clock; all state updates on posedge
//  rst         in   1           asynchronous, active-high reset
//  gameover    in   1           synchronous clear, same effect as reset
//  fire        in   1           fire key level; held = auto-fire
//  reimux      in   10          player x, 0..440
//  reimuy      in   10          player y, 0..480
//  shot_valid  out  NSHOT       bit i = slot i active
//  shot_x      out  10*NSHOT    slot i x at [10*i+9:10*i]
//  shot_y      out  10*NSHOT    slot i y at [10*i+9:10*i]
//  shot_fired  out  1           one-tick pulse on the edge a shot spawns
// BEHAVIOUR
//  Reset and clear:
//  - rst high: shot_valid=0, all shot_x/shot_y=0, cooldown=0, shot_fired=0.
//    Takes effect immediately, with no clock edge required.
//  - gameover high at an edge: same values as reset, loaded synchronously.
//    Takes priority over spawn and move.
//  Per edge, all slots update in parallel from pre-edge state:
//  - Move: valid slot with y>=SPEED gets y<=y-SPEED.
//  - Retire: valid slot with y<SPEED gets valid<=0; x/y hold their last value.
//  - Spawn condition: fire=1 AND cooldown==0 AND at least one slot invalid pre-edge.
//  - Spawn action: the lowest-index free slot gets valid<=1, x<=reimux+X_OFFSET
//    (10-bit, no clamp; max 456 with defaults), y<=reimuy.
//    The new shot is not moved on its spawn edge.
//  - A slot that retires on this edge is NOT free until the next edge.
//  - Cooldown counter, width $clog2(COOLDOWN):
//    - loaded with COOLDOWN-1 on a spawn edge;
//    - otherwise decremented by 1 while nonzero.
//    - Spawn spacing with fire held = COOLDOWN ticks.
//  - Pool full: fire is ignored, cooldown is not loaded, shot_fired stays 0.
//  - shot_fired is registered: 1 exactly on spawn edges, 0 otherwise.
//  - Latency: fire high before edge t gives the shot visible on outputs after edge t.
//  Shot lifetime from spawn at y0: floor(y0/SPEED) moves, then retire on the next edge.
// TESTING
//  1 Reset: assert rst asynchronously mid-flight.
//    -> all outputs 0 before the next clk22 edge.
//  2 Single shot: reimux=220, reimuy=360, fire for 1 tick.
//    -> slot0 valid, x=236, y=360.
//    -> y=356 one tick later, y=0 after 90 ticks.
//    -> slot0 invalid on tick 91; shot_fired pulsed once.
//  3 Auto-fire, fire held, reimuy=360:
//    -> spawns at ticks 0, 8, 16, 24 into slots 0..3.
//    -> no spawn at tick 32; shot_fired=0.
//    -> slot0 retires at tick 91; next spawn into slot0 at tick 92.
//  4 Cooldown: fire pulsed at tick 0, then at tick 5, then at tick 8.
//    -> spawns at tick 0 and tick 8 only.
//  5 Gameover: with 3 active shots, pulse gameover 1 tick while fire=1.
//    -> all slots cleared, no spawn, cooldown=0.
//    -> fire next tick spawns into slot0.
//  6 Top edge: reimuy=2, fire.
//    -> spawned at y=2, retired the next tick (2<SPEED).
//    -> slot free for a spawn one tick after retirement.

Source files
------------

// File: rtl/reimu_shot_if.sv
// Player-side bundle for the shot manager: fire/position in, slot positions out.
// The master modport belongs to the player-movement stage, the slave to reimu_shot.
interface reimu_shot_if #(
    parameter int NSHOT = 4
);
    logic                  gameover;
    logic                  fire;
    logic [9:0]            reimux;
    logic [9:0]            reimuy;
    logic [NSHOT-1:0]      shot_valid;
    logic [10*NSHOT-1:0]   shot_x;
    logic [10*NSHOT-1:0]   shot_y;
    logic                  shot_fired;

    modport master (
        output gameover, fire, reimux, reimuy,
        input  shot_valid, shot_x, shot_y, shot_fired
    );

    modport slave (
        input  gameover, fire, reimux, reimuy,
        output shot_valid, shot_x, shot_y, shot_fired
    );
endinterface

// File: rtl/reimu_shot.sv
// Player shot manager: spawns shots from the player position into a fixed slot
// pool, scrolls them upward each tick and retires them past the top edge.
module reimu_shot #(
    parameter int NSHOT    = 4,
    parameter int SPEED    = 4,
    parameter int COOLDOWN = 8,
    parameter int X_OFFSET = 16
) (
    input  logic        clk22,
    input  logic        rst,
    reimu_shot_if.slave bus
);
    localparam int              CW      = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [9:0]      SPEED_V = 10'(SPEED);
    localparam logic [9:0]      XOFF_V  = 10'(X_OFFSET);
    localparam logic [CW-1:0]   CD_LOAD = CW'(COOLDOWN - 1);

    logic [NSHOT-1:0] valid;
    logic [9:0]       xs [NSHOT];
    logic [9:0]       ys [NSHOT];
    logic [CW-1:0]    cooldown;
    logic             fired;
    logic [NSHOT-1:0] spawn_mask;
    logic             spawn;

    // Lowest clear bit of valid: adding one ripples through the trailing ones.
    assign spawn_mask = ~valid & (valid + NSHOT'(1));
    assign spawn      = bus.fire && (cooldown == '0) && (|(~valid));

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            valid    <= '0;
            cooldown <= '0;
            fired    <= 1'b0;
            for (int i = 0; i < NSHOT; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
        end else if (bus.gameover) begin
            valid    <= '0;
            cooldown <= '0;
            fired    <= 1'b0;
            for (int i = 0; i < NSHOT; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
        end else begin
            // Spawn targets a slot that is free pre-edge, so it never collides with a move.
            for (int i = 0; i < NSHOT; i++) begin
                if (spawn && spawn_mask[i]) begin
                    valid[i] <= 1'b1;
                    xs[i]    <= bus.reimux + XOFF_V;
                    ys[i]    <= bus.reimuy;
                end else if (valid[i]) begin
                    if (ys[i] >= SPEED_V) begin
                        ys[i] <= ys[i] - SPEED_V;
                    end else begin
                        valid[i] <= 1'b0;
                    end
                end
            end
            if (spawn) begin
                cooldown <= CD_LOAD;
            end else if (cooldown != '0) begin
                cooldown <= cooldown - CW'(1);
            end
            fired <= spawn;
        end
    end

    assign bus.shot_valid = valid;
    assign bus.shot_fired = fired;

    for (genvar g = 0; g < NSHOT; g++) begin : g_out
        assign bus.shot_x[10*g +: 10] = xs[g];
        assign bus.shot_y[10*g +: 10] = ys[g];
    end
endmodule
